// File: rtl/serializador.sv
// Parallel-to-serial transmitter.
// Accepts an N-bit word over a valid/ready handshake and shifts it out LSB
// first, one bit every DIV clocks. When requested, an N-bit sync pattern is
// sent ahead of the word. A new frame can follow the last bit of the previous
// one with no idle gap.
module serializador #(
  parameter int N      = 4,
  parameter int logN   = 2,
  parameter int DIV    = 1,
  parameter int logDIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] dato_par,
  input  logic         dato_valido,
  output logic         listo,
  input  logic [N-1:0] patron_sync,
  input  logic         sync_en,
  output logic         salida_serie,
  output logic         bit_valido,
  output logic         inicio_trama,
  output logic         ocupado
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATOS = 2'd2
  } state_t;

  localparam logic [logN-1:0]   BitLast = logN'(N - 1);
  localparam logic [logDIV-1:0] DivLast = logDIV'(DIV - 1);

  state_t              state_q;
  logic [N-1:0]        dataSr_q;
  logic [N-1:0]        syncSr_q;
  logic [logN-1:0]     bitCnt_q;
  logic [logDIV-1:0]   divCnt_q;
  logic                syncEn_q;

  logic divWrap;
  logic lastBit;
  logic accept;

  assign divWrap = (divCnt_q == DivLast);
  assign lastBit = (bitCnt_q == BitLast);

  // Ready is asserted while idle, and also in the very last clock of the data
  // phase so the next word can be loaded without a gap cycle.
  assign listo  = (state_q == IDLE) || ((state_q == DATOS) && lastBit && divWrap);
  assign accept = dato_valido && listo;

  assign ocupado      = (state_q != IDLE);
  assign bit_valido   = (state_q != IDLE) && (divCnt_q == '0);
  assign inicio_trama = (bitCnt_q == '0) &&
                        ((state_q == SYNC) || ((state_q == DATOS) && !syncEn_q));
  assign salida_serie = (state_q == SYNC)  ? syncSr_q[0] :
                        (state_q == DATOS) ? dataSr_q[0] : 1'b0;

  // Frame sequencer: captures a word on accept, paces bits with the divider
  // and walks IDLE -> (SYNC) -> DATOS -> IDLE, chaining frames back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dataSr_q <= '0;
      syncSr_q <= '0;
      bitCnt_q <= '0;
      divCnt_q <= '0;
      syncEn_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dataSr_q <= dato_par;
            syncEn_q <= sync_en;
            if (sync_en) begin
              syncSr_q <= patron_sync;
            end
            state_q  <= sync_en ? SYNC : DATOS;
            bitCnt_q <= '0;
            divCnt_q <= '0;
          end
        end
        SYNC: begin
          if (divWrap) begin
            divCnt_q <= '0;
            syncSr_q <= syncSr_q >> 1;
            if (lastBit) begin
              state_q  <= DATOS;
              bitCnt_q <= '0;
            end else begin
              bitCnt_q <= bitCnt_q + logN'(1);
            end
          end else begin
            divCnt_q <= divCnt_q + logDIV'(1);
          end
        end
        DATOS: begin
          if (divWrap) begin
            divCnt_q <= '0;
            if (lastBit) begin
              bitCnt_q <= '0;
              if (accept) begin
                dataSr_q <= dato_par;
                syncEn_q <= sync_en;
                if (sync_en) begin
                  syncSr_q <= patron_sync;
                end
                state_q <= sync_en ? SYNC : DATOS;
              end else begin
                dataSr_q <= dataSr_q >> 1;
                state_q  <= IDLE;
              end
            end else begin
              dataSr_q <= dataSr_q >> 1;
              bitCnt_q <= bitCnt_q + logN'(1);
            end
          end else begin
            divCnt_q <= divCnt_q + logDIV'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          bitCnt_q <= '0;
          divCnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador.
// Two instances: unit 0 uses DIV=1, unit 1 uses DIV=3. Every clock the
// outputs of both units are compared against a per-cycle expectation queue
// that is filled when the bench's own model decides a word is accepted.
module tb_serializador;

  typedef struct packed {
    logic ser;
    logic bv;
    logic it;
    logic oc;
    logic li;
  } exp_t;

  typedef struct {
    logic       se;
    logic [3:0] pat;
    logic [3:0] dat;
    logic [7:0] bits;
    int         nb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic [3:0] datoPar    [2];
  logic [3:0] patronSync [2];
  logic       datoValido [2];
  logic       syncEn     [2];
  logic       listo      [2];
  logic       salidaSerie[2];
  logic       bitValido  [2];
  logic       inicioTrama[2];
  logic       ocupado    [2];

  serializador #(.N(4), .logN(2), .DIV(1), .logDIV(1)) dut0 (
    .clk          (clk),
    .rst_n        (rstN),
    .dato_par     (datoPar[0]),
    .dato_valido  (datoValido[0]),
    .listo        (listo[0]),
    .patron_sync  (patronSync[0]),
    .sync_en      (syncEn[0]),
    .salida_serie (salidaSerie[0]),
    .bit_valido   (bitValido[0]),
    .inicio_trama (inicioTrama[0]),
    .ocupado      (ocupado[0])
  );

  serializador #(.N(4), .logN(2), .DIV(3), .logDIV(2)) dut1 (
    .clk          (clk),
    .rst_n        (rstN),
    .dato_par     (datoPar[1]),
    .dato_valido  (datoValido[1]),
    .listo        (listo[1]),
    .patron_sync  (patronSync[1]),
    .sync_en      (syncEn[1]),
    .salida_serie (salidaSerie[1]),
    .bit_valido   (bitValido[1]),
    .inicio_trama (inicioTrama[1]),
    .ocupado      (ocupado[1])
  );

  exp_t       expQ0[$];
  exp_t       expQ1[$];
  exp_t       cur      [2];
  logic       expListo [2];
  logic [7:0] pendBits [2];
  int         pendNb   [2];
  bit         accepted [2];
  int         checks   = 0;
  int         failures = 0;
  int         cycleNo  = 0;
  vec_t       vecs[4];

  function automatic exp_t idleRec();
    exp_t r;
    r.ser = 1'b0;
    r.bv  = 1'b0;
    r.it  = 1'b0;
    r.oc  = 1'b0;
    r.li  = 1'b1;
    return r;
  endfunction

  function automatic int divOf(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Model: expand an accepted frame into one expectation record per clock.
  task automatic pushFrame(input int u);
    exp_t r;
    int   d;
    d = divOf(u);
    for (int b = 0; b < pendNb[u]; b++) begin
      for (int k = 0; k < d; k++) begin
        r.ser = pendBits[u][b];
        r.bv  = (k == 0);
        r.it  = (b == 0);
        r.oc  = 1'b1;
        r.li  = (b == pendNb[u] - 1) && (k == d - 1);
        if (u == 0) expQ0.push_back(r);
        else        expQ1.push_back(r);
      end
    end
  endtask

  task automatic popExp(input int u);
    if (u == 0) cur[0] = (expQ0.size() > 0) ? expQ0.pop_front() : idleRec();
    else        cur[1] = (expQ1.size() > 0) ? expQ1.pop_front() : idleRec();
  endtask

  task automatic checkBit(input string name, input int u, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s unit%0d cycle %0d: got %b expected %b", name, u, cycleNo, act, want);
    end
  endtask

  task automatic checkOutput(input int u);
    checkBit("salida_serie", u, salidaSerie[u], cur[u].ser);
    checkBit("bit_valido",   u, bitValido[u],   cur[u].bv);
    checkBit("inicio_trama", u, inicioTrama[u], cur[u].it);
    checkBit("ocupado",      u, ocupado[u],     cur[u].oc);
    checkBit("listo",        u, listo[u],       cur[u].li);
  endtask

  // One clock: model the accept at the rising edge, compare on the falling edge.
  task automatic stepCycle();
    @(posedge clk);
    cycleNo++;
    for (int u = 0; u < 2; u++) begin
      accepted[u] = 1'b0;
      if (rstN && datoValido[u] && expListo[u]) begin
        pushFrame(u);
        accepted[u] = 1'b1;
      end
    end
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      popExp(u);
      checkOutput(u);
      expListo[u] = cur[u].li;
    end
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Offer a word and keep it offered until the model sees it accepted.
  task automatic applyStimulus(input int u, input logic se, input logic [3:0] pat,
                               input logic [3:0] dat, input logic [7:0] bits, input int nb);
    int waited;
    datoPar[u]    = dat;
    patronSync[u] = pat;
    syncEn[u]     = se;
    datoValido[u] = 1'b1;
    pendBits[u]   = bits;
    pendNb[u]     = nb;
    waited        = 0;
    do begin
      stepCycle();
      waited++;
    end while (!accepted[u] && waited < 40);
    if (!accepted[u]) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout unit%0d cycle %0d: got no accept expected accept", u, cycleNo);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      datoPar[u]    = 4'h0;
      patronSync[u] = 4'h0;
      datoValido[u] = 1'b0;
      syncEn[u]     = 1'b0;
      cur[u]        = idleRec();
      expListo[u]   = 1'b1;
      pendBits[u]   = 8'h00;
      pendNb[u]     = 4;
      accepted[u]   = 1'b0;
    end
    vecs[0] = '{se: 1'b0, pat: 4'b0000, dat: 4'b1011, bits: 8'b0000_1011, nb: 4};
    vecs[1] = '{se: 1'b1, pat: 4'b0110, dat: 4'b1001, bits: 8'b1001_0110, nb: 8};
    vecs[2] = '{se: 1'b0, pat: 4'b1111, dat: 4'b0000, bits: 8'b0000_0000, nb: 4};
    vecs[3] = '{se: 1'b1, pat: 4'b1111, dat: 4'b0000, bits: 8'b0000_1111, nb: 8};

    // Reset state, with a word offered that must not be taken.
    rstN          = 1'b0;
    datoValido[0] = 1'b1;
    datoPar[0]    = 4'b1111;
    #2;
    for (int u = 0; u < 2; u++) checkOutput(u);
    runIdle(2);
    datoValido[0] = 1'b0;
    rstN = 1'b1;
    runIdle(2);

    // Table of single frames on the DIV=1 unit; inputs scrambled after accept.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, vecs[i].se, vecs[i].pat, vecs[i].dat, vecs[i].bits, vecs[i].nb);
      datoValido[0] = 1'b0;
      datoPar[0]    = ~vecs[i].dat;
      patronSync[0] = ~vecs[i].pat;
      syncEn[0]     = ~vecs[i].se;
      runIdle(vecs[i].nb + 2);
    end

    // Back-to-back frames with valid held high.
    applyStimulus(0, 1'b0, 4'b0000, 4'b0001, 8'b0000_0001, 4);
    applyStimulus(0, 1'b0, 4'b0000, 4'b1110, 8'b0000_1110, 4);
    datoValido[0] = 1'b0;
    runIdle(6);

    // Slow bit rate on the DIV=3 unit, plain then with sync.
    applyStimulus(1, 1'b0, 4'b0000, 4'b0101, 8'b0000_0101, 4);
    datoValido[1] = 1'b0;
    runIdle(14);
    applyStimulus(1, 1'b1, 4'b0110, 4'b1001, 8'b1001_0110, 8);
    datoValido[1] = 1'b0;
    runIdle(26);

    // Reset asserted during bit 2 aborts the frame at once.
    applyStimulus(0, 1'b0, 4'b0000, 4'b1011, 8'b0000_1011, 4);
    datoValido[0] = 1'b0;
    runIdle(2);
    rstN = 1'b0;
    #1;
    expQ0.delete();
    expQ1.delete();
    for (int u = 0; u < 2; u++) begin
      cur[u]      = idleRec();
      expListo[u] = 1'b1;
      checkOutput(u);
    end
    datoValido[0] = 1'b1;
    runIdle(2);
    datoValido[0] = 1'b0;
    rstN = 1'b1;
    applyStimulus(0, 1'b0, 4'b0000, 4'b1100, 8'b0000_1100, 4);
    datoValido[0] = 1'b0;
    runIdle(6);

    // Inputs disturbed mid-frame; a held word is taken exactly once.
    applyStimulus(0, 1'b1, 4'b1010, 4'b0011, 8'b0011_1010, 8);
    patronSync[0] = 4'b0101;
    applyStimulus(0, 1'b0, 4'b0101, 4'b1000, 8'b0000_1000, 4);
    datoValido[0] = 1'b0;
    datoPar[0]    = 4'hF;
    patronSync[0] = 4'hF;
    syncEn[0]     = 1'b1;
    runIdle(2);
    datoPar[0] = 4'h0;
    runIdle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializador.md
Name: serializador

Overview:
- Parallel-to-serial transmitter; the transmit end of the serial link whose receive end deserialises N-bit words and matches them against patterns.
- Accepts an N-bit word over a valid/ready handshake and shifts it out LSB first, one bit per bit period.
- Optionally prepends an N-bit sync pattern, so the receiver's pattern comparators can lock on.
- Supports back-to-back frames with no idle gap.

Parameters:
- N, 4: word width in bits.
- logN, 2: bit-counter width; must satisfy 2^logN >= N (counter holds 0..N-1).
- DIV, 1: clock cycles per serial bit (>= 1).
- logDIV, 1: divider-counter width; must satisfy 2^logDIV >= DIV.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dato_par  in  N  parallel word to transmit.
- dato_valido  in  1  dato_par is valid.
- listo  out  1  transmitter can accept a word this cycle.
- patron_sync  in  N  sync pattern sent ahead of the word when sync_en = 1.
- sync_en  in  1  prepend sync pattern to this frame.
- salida_serie  out  1  serial data, LSB first.
- bit_valido  out  1  one-cycle strobe on the first clk of each bit period.
- inicio_trama  out  1  high for the whole first bit period of a frame.
- ocupado  out  1  frame in progress.

Behaviour:
- Reset (rst_n low, async): state IDLE, all counters 0, shift registers 0. Output values during reset: salida_serie = 0, bit_valido = 0, inicio_trama = 0, ocupado = 0, listo = 1. Words offered during reset are not accepted.
- Reset asserted mid-frame: frame aborted immediately. No partial resume after release.
- States:
  - IDLE: no transmission.
  - SYNC: sending the N bits of the sync pattern.
  - DATOS: sending the N bits of the data word.
- Accept: occurs at a rising edge where dato_valido = 1 and listo = 1.
  - Captures dato_par into the data shift register.
  - Captures sync_en; when it is 1, also captures patron_sync.
  - Next state is SYNC if the captured sync_en = 1, else DATOS.
  - bit counter = 0, divider counter = 0.
- listo is combinational: 1 in IDLE, or in DATOS when bit counter = N-1 and divider counter = DIV-1. It is 0 otherwise, including all of SYNC.
- Latency: the first bit appears on salida_serie in the cycle right after the accepting edge.
- Bit timing:
  - Each bit is held for DIV cycles.
  - The divider counts 0..DIV-1; when it wraps, the active shift register shifts right by 1 and the bit counter increments.
  - salida_serie = bit 0 of the active shift register (the sync register in SYNC, the data register in DATOS).
- Transitions:
  - SYNC: after its last bit wraps, go to DATOS with bit counter = 0.
  - DATOS: after its last bit wraps, go to IDLE, unless an accept occurs in that same cycle. In that case, load the new word and go to SYNC or DATOS per the new sync_en, with no gap cycle.
- Outputs:
  - bit_valido = 1 when state != IDLE and divider counter = 0.
  - inicio_trama = 1 during bit 0 of SYNC, or bit 0 of DATOS when the frame has no sync.
  - ocupado = 1 when state != IDLE.
  - In IDLE, salida_serie = 0.
- Frame length: N·DIV cycles without sync, 2N·DIV cycles with sync.
- Input stability: changes on dato_par, patron_sync and sync_en after accept have no effect on the frame in progress. dato_valido held high with listo = 0 is simply not accepted; the word must be held until accepted.

Test Plan:
1. N=4, DIV=1, dato_par = 4'b1011, sync_en = 0, accept at edge 0 -> salida_serie = 1,1,0,1 in cycles 1-4; bit_valido high cycles 1-4; inicio_trama high cycle 1 only; listo high cycle 4; IDLE with salida_serie = 0 at cycle 5.
2. patron_sync = 4'b0110, sync_en = 1, dato_par = 4'b1001 -> serial 0,1,1,0,1,0,0,1 over cycles 1-8; listo = 0 cycles 1-7 and high cycle 8; ocupado high cycles 1-8.
3. Back-to-back: dato_valido held high with 4'b0001 then 4'b1110, sync_en = 0 -> 8 contiguous bits 1,0,0,0,0,1,1,1; ocupado never drops; inicio_trama pulses in cycles 1 and 5.
4. DIV=3, dato_par = 4'b0101 -> each bit held 3 cycles (1,1,1,0,0,0,1,1,1,0,0,0); bit_valido pulses in cycles 1, 4, 7, 10.
5. Reset mid-frame: rst_n driven low during bit 2 -> all outputs go to reset values immediately and listo = 1. After release, a new word 4'b1100 transmits cleanly as 0,0,1,1.
6. dato_par and patron_sync changed mid-frame; dato_valido held while listo = 0 -> transmitted bits reflect only values captured at accept; the held word is accepted exactly once, at the cycle where listo = 1.
